mem_controller: RTL and testbench
=================================

MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 Parameter WORD, default 16: data word width in bits; SHALL be a multiple of 8 (16 is the supported build).
REQ-002 Parameter BYTES, default 65536: memory size in bytes; ADDR_W = $clog2(BYTES).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req_valid  input  1  CPU request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_byte  input  1  1 = byte access, 0 = word access.
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  WORD  store data; a byte store uses bits 7:0.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  CPU accepts the response.
REQ-013 resp_rdata  output  WORD  load result.
REQ-014 resp_err  output  1  misaligned word access.
REQ-015 mem_rd  output  1  read strobe to memory read port 0.
REQ-016 mem_rd_addr  output  ADDR_W  word index to memory read port 0.
REQ-017 mem_rd_data  input  WORD  memory read port 0 data, registered by memory on posedge.
REQ-018 mem_wr  output  WORD/8  per-byte write enables.
REQ-019 mem_wr_addr  output  ADDR_W  word index for the write.
REQ-020 mem_wr_data  output  WORD  write data.

Function
REQ-021 The FSM SHALL have states IDLE, RD, WR, RESP.
REQ-022 req_ready SHALL be 1 only in IDLE with rst low; a request is accepted on a posedge with req_valid && req_ready.
REQ-023 On accept, addr/write/byte/wdata SHALL be latched; later input changes have no effect until the next accept.
REQ-024 Accept transitions:
- misaligned word access (req_byte=0, req_addr[0]=1) -> RESP with err=1, no memory strobe;
- else store -> WR;
- else load -> RD.
REQ-025 RD (one cycle): mem_rd=1, mem_rd_addr = latched addr >> 1 (zero-extended); next state RESP.
REQ-026 WR (one cycle): mem_wr_addr = addr >> 1; next state RESP with err=0.
- Word store: mem_wr = 2'b11, mem_wr_data = wdata.
- Byte store: mem_wr = 2'b01 if addr[0]=0, 2'b10 if addr[0]=1; mem_wr_data = {wdata[7:0], wdata[7:0]}.
REQ-027 Outside RD, mem_rd SHALL be 0; outside WR, mem_wr SHALL be 0. mem_rd and mem_wr SHALL never both be nonzero.
REQ-028 In RESP, resp_valid SHALL be 1.
- Load: resp_rdata is computed combinationally from mem_rd_data. Word load: resp_rdata = mem_rd_data. Byte load: zero-extended mem_rd_data[7:0] if addr[0]=0, else mem_rd_data[15:8].
- Store or error: resp_rdata = 0.
REQ-029 resp_valid, resp_rdata and resp_err SHALL hold stable in RESP until a posedge with resp_ready=1; the FSM then returns to IDLE.
REQ-030 Latency from accept edge to resp_valid high: load and store 2 cycles, error 1 cycle. Minimum issue interval with resp_ready held high: 3 cycles (2 for error).
REQ-031 Endianness SHALL be little-endian: the even byte address maps to bits 7:0.
REQ-032 Outside RESP, resp_valid, resp_rdata and resp_err SHALL be 0.

Reset
REQ-033 While rst is high, regardless of clk: state = IDLE, latched request cleared, req_ready = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_rd = 0, mem_wr = 0, and all address/data outputs = 0.
REQ-034 Reset asserted in RD, WR or RESP SHALL abort the transaction: no response is produced and no write strobe is driven after rst rises. Operation SHALL resume from IDLE on the first posedge after rst falls.

Verification
REQ-035 Word store: addr 0x0010, wdata 0x1234 -> WR cycle shows mem_wr=11, mem_wr_addr=0x0008, mem_wr_data=0x1234; resp_valid 2 cycles after accept, err=0.
REQ-036 Byte store then word load: store byte 0xAB to 0x0011, then load word 0x0010 -> mem_wr=10 with data 0xABAB; the load returns 0xAB34.
REQ-037 Byte load from odd and even address: word at 0x0020 = 0xBEEF -> load byte 0x0021 returns 0x00BE; load byte 0x0020 returns 0x00EF.
REQ-038 Misaligned word load at 0x0003 -> resp_err=1, resp_rdata=0, mem_rd never asserted, resp_valid 1 cycle after accept.
REQ-039 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_* stable throughout, req_ready=0; a new req_valid is not accepted until the cycle after resp_ready=1.
REQ-040 Reset mid-operation: assert rst in the WR cycle of a store -> mem_wr drops to 0 immediately and resp_valid never rises; after release, req_ready=1 on the first cycle.

Source files
------------

// File: rtl/mem_controller.sv
// CPU-to-SRAM bridge: word/byte loads and stores, little-endian.
// One request in flight; misaligned word access answers with an error.
module mem_controller #(
  parameter  int WORD   = 16,
  parameter  int BYTES  = 65536,
  localparam int ADDR_W = $clog2(BYTES),
  localparam int BL     = WORD / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WORD-1:0]   mem_rd_data,
  output logic [BL-1:0]     mem_wr,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WORD-1:0]   mem_wr_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t state;
  state_t next;

  logic [ADDR_W-1:0] l_addr;
  logic [WORD-1:0]   l_wdata;
  logic              l_write;
  logic              l_byte;
  logic              l_err;

  logic              accept;
  logic              misalign;
  logic [ADDR_W-1:0] word_idx;
  logic [7:0]        lane_byte;
  logic [BL-1:0]     lane_we;

  assign accept    = req_valid && req_ready;
  assign misalign  = !req_byte && req_addr[0];
  assign word_idx  = {1'b0, l_addr[ADDR_W-1:1]};
  assign lane_byte = l_addr[0] ? mem_rd_data[15:8]
                               : mem_rd_data[7:0];
  assign lane_we   = {{(BL-1){1'b0}}, 1'b1} << l_addr[0];

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // Capture the request on accept so later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_addr  <= '0;
      l_wdata <= '0;
      l_write <= 1'b0;
      l_byte  <= 1'b0;
      l_err   <= 1'b0;
    end else if (accept) begin
      l_addr  <= req_addr;
      l_wdata <= req_wdata;
      l_write <= req_write;
      l_byte  <= req_byte;
      l_err   <= misalign;
    end
  end

  // Next-state: errors skip memory, loads read, stores write.
  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (misalign)       next = RESP;
          else if (req_write) next = WR;
          else                next = RD;
        end
      end
      RD:   next = RESP;
      WR:   next = RESP;
      RESP: if (resp_ready) next = IDLE;
    endcase
  end

  // Outputs decoded from state; everything idles at zero.
  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    resp_err    = 1'b0;
    mem_rd      = 1'b0;
    mem_rd_addr = '0;
    mem_wr      = '0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    unique case (state)
      IDLE: req_ready = !rst;
      RD: begin
        mem_rd      = 1'b1;
        mem_rd_addr = word_idx;
      end
      WR: begin
        mem_wr_addr = word_idx;
        if (l_byte) begin
          mem_wr      = lane_we;
          mem_wr_data = {BL{l_wdata[7:0]}};
        end else begin
          mem_wr      = '1;
          mem_wr_data = l_wdata;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = l_err;
        if (!l_write && !l_err) begin
          if (l_byte)
            resp_rdata = {{(WORD-8){1'b0}}, lane_byte};
          else
            resp_rdata = mem_rd_data;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: directed cases plus random traffic,
// checked against a byte-array model of memory contents.
module tb_mem_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd;
  logic [15:0] mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic [1:0]  mem_wr;
  logic [15:0] mem_wr_addr;
  logic [15:0] mem_wr_data;

  logic [15:0] tmem [0:32767];
  logic [7:0]  rmem [0:65535];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  mem_controller #(.WORD(16), .BYTES(65536)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rd(mem_rd), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .mem_wr(mem_wr), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous SRAM: registered read port, byte-enabled write port.
  always @(posedge clk) begin
    if (mem_wr[0]) tmem[mem_wr_addr[14:0]][7:0]  <= mem_wr_data[7:0];
    if (mem_wr[1]) tmem[mem_wr_addr[14:0]][15:8] <= mem_wr_data[15:8];
    if (mem_rd)    mem_rd_data <= tmem[mem_rd_addr[14:0]];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction, entered and left just after a negedge.
  task automatic txn(input logic wr, input logic by,
                     input logic [15:0] a, input logic [15:0] wd,
                     input int bp, output int acc,
                     output logic [15:0] rd);
    logic        mis;
    logic [15:0] exp_rd;
    logic [1:0]  exp_we;
    logic [15:0] exp_wd;
    logic [15:0] rd_a, wr_a, wr_d;
    logic [1:0]  wr_e;
    int lat, rd_n, wr_n, tmo;
    mis  = !by && a[0];
    rd_a = '0; wr_a = '0; wr_d = '0; wr_e = '0;
    if (wr || mis)  exp_rd = 16'h0;
    else if (by)    exp_rd = {8'h00, rmem[a]};
    else            exp_rd = {rmem[a | 16'd1], rmem[a]};
    exp_we = by ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
    exp_wd = by ? {wd[7:0], wd[7:0]} : wd;
    tmo = 0;
    while (!req_ready && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    chk("ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_byte  = by;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_byte  = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    lat = 1; rd_n = 0; wr_n = 0;
    while (!resp_valid && lat < 8) begin
      chk("rd_wr_excl", {31'b0, mem_rd && (mem_wr != 0)}, 32'd0);
      chk("ready_busy", {31'b0, req_ready}, 32'd0);
      if (mem_rd) begin
        rd_n++;
        rd_a = mem_rd_addr;
      end
      if (mem_wr != 0) begin
        wr_n++;
        wr_a = mem_wr_addr;
        wr_d = mem_wr_data;
        wr_e = mem_wr;
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), mis ? 32'd1 : 32'd2);
    chk("rd_strobes", 32'(rd_n), (!wr && !mis) ? 32'd1 : 32'd0);
    chk("wr_strobes", 32'(wr_n), (wr && !mis) ? 32'd1 : 32'd0);
    if (!wr && !mis)
      chk("rd_addr", {16'h0, rd_a}, {17'h0, a[15:1]});
    if (wr && !mis) begin
      chk("wr_en", {30'b0, wr_e}, {30'b0, exp_we});
      chk("wr_addr", {16'h0, wr_a}, {17'h0, a[15:1]});
      chk("wr_data", {16'h0, wr_d}, {16'h0, exp_wd});
      rmem[a] = wd[7:0];
      if (!by) rmem[a | 16'd1] = wd[15:8];
    end
    rd = resp_rdata;
    for (int i = 0; i <= bp; i++) begin
      chk("resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("resp_err", {31'b0, resp_err}, {31'b0, mis});
      chk("resp_rdata", {16'h0, resp_rdata}, {16'h0, exp_rd});
      chk("ready_resp", {31'b0, req_ready}, 32'd0);
      chk("strobe_resp", {29'b0, mem_rd, mem_wr}, 32'd0);
      if (i < bp) begin
        req_valid = 1'b1;
        req_write = 1'($urandom);
        req_addr  = 16'($urandom);
        @(negedge clk);
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_valid", {31'b0, resp_valid}, 32'd0);
    chk("post_err", {31'b0, resp_err}, 32'd0);
    chk("post_rdata", {16'h0, resp_rdata}, 32'd0);
    chk("post_ready", {31'b0, req_ready}, 32'd1);
  endtask

  int          acc_a, acc_b;
  logic [15:0] rd;

  initial begin
    for (int i = 0; i < 32768; i++) tmem[i] = 16'h0;
    for (int i = 0; i < 65536; i++) rmem[i] = 8'h0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_byte   = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_strobes", {29'b0, mem_rd, mem_wr}, 32'd0);
    chk("rst_addrs", {mem_rd_addr, mem_wr_addr}, 32'd0);
    chk("rst_data", {resp_rdata, mem_wr_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready", {31'b0, req_ready}, 32'd1);

    // Word store, then byte store into the odd lane.
    txn(1'b1, 1'b0, 16'h0010, 16'h1234, 0, acc_a, rd);
    txn(1'b1, 1'b1, 16'h0011, 16'h55AB, 0, acc_b, rd);
    chk("interval_ok", 32'(acc_b - acc_a), 32'd3);
    txn(1'b0, 1'b0, 16'h0010, 16'h0, 0, acc_a, rd);
    chk("word_merge", {16'h0, rd}, 32'h0000AB34);

    // Byte loads from both lanes of 0xBEEF.
    txn(1'b1, 1'b0, 16'h0020, 16'hBEEF, 0, acc_a, rd);
    txn(1'b0, 1'b1, 16'h0021, 16'h0, 0, acc_a, rd);
    chk("byte_odd", {16'h0, rd}, 32'h000000BE);
    txn(1'b0, 1'b1, 16'h0020, 16'h0, 0, acc_a, rd);
    chk("byte_even", {16'h0, rd}, 32'h000000EF);

    // Misaligned word load, then issue interval after an error.
    txn(1'b0, 1'b0, 16'h0003, 16'h0, 0, acc_a, rd);
    chk("mis_rdata", {16'h0, rd}, 32'd0);
    txn(1'b0, 1'b0, 16'h0010, 16'h0, 0, acc_b, rd);
    chk("interval_err", 32'(acc_b - acc_a), 32'd2);

    // Backpressure: five stalled cycles in RESP.
    txn(1'b0, 1'b0, 16'h0020, 16'h0, 5, acc_a, rd);
    chk("bp_rdata", {16'h0, rd}, 32'h0000BEEF);

    // Reset during WR aborts the store.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_byte  = 1'b0;
    req_addr  = 16'h0040;
    req_wdata = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_in_wr", {30'b0, mem_wr}, 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("abort_wr", {30'b0, mem_wr}, 32'd0);
    chk("abort_addr", {mem_wr_addr, mem_wr_data}, 32'd0);
    chk("abort_valid", {31'b0, resp_valid}, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold", {30'b0, resp_valid, mem_rd}, 32'd0);
      chk("abort_hold_wr", {30'b0, mem_wr}, 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("resume_ready", {31'b0, req_ready}, 32'd1);
    chk("resume_valid", {31'b0, resp_valid}, 32'd0);
    txn(1'b0, 1'b0, 16'h0040, 16'h0, 0, acc_a, rd);
    chk("abort_nowrite", {16'h0, rd}, 32'd0);

    // Random mix of loads, stores and errors on a small window.
    for (int n = 0; n < 150; n++) begin
      txn(1'($urandom), 1'($urandom),
          16'($urandom_range(0, 63)), 16'($urandom),
          int'($urandom_range(0, 2)), acc_a, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
